// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares the single data-memory port between the CPU load/store path and an
// external host port (boot-time loading and runtime debug access).
//
// Policy:
//   - The CPU has priority; the host is granted whenever the CPU is idle.
//   - A starvation counter forces a host grant once the host has been denied
//     MAX_WAIT consecutive cycles. The CPU is stalled on that cycle.
//   - While reset is high only host writes are granted (boot load). CPU
//     accesses never reach memory, and host reads wait for reset release.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   cpu_req/we/funct3/addr/wdata CPU access request and operands
//   cpu_rdata                   load data to CPU (combinational copy of mem_rdata)
//   cpu_stall                   CPU must hold its access and retry next cycle
//   host_req/we/addr/wdata      host request, held stable until host_gnt
//   host_gnt                    host access performed this cycle
//   host_rdata, host_rvalid     registered host read data, 1-cycle valid pulse
//   mem_we/funct3/addr/wdata    data_mem request
//   mem_rdata                   data_mem combinational read data

module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,

  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,

  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MaxWait   = 4'(MAX_WAIT);
  localparam logic [2:0] Funct3Word = 3'b010;

  logic [3:0] wait_cnt;
  logic       forced;
  logic       host_rd_gnt;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  assign forced = (wait_cnt == MaxWait);

  always_comb begin
    host_gnt  = 1'b0;
    cpu_stall = 1'b0;
    if (reset) begin
      // Boot load: only host writes go through; CPU is held off memory but
      // not stalled, since it is itself in reset.
      host_gnt  = host_req & host_we;
      cpu_stall = 1'b0;
    end else begin
      host_gnt  = host_req & (~cpu_req | forced);
      cpu_stall = cpu_req & host_gnt;
    end
  end

  assign host_rd_gnt = host_gnt & ~host_we;

  // ---------------------------------------------------------------------------
  // Memory mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we     = cpu_req & cpu_we & ~reset;
    mem_funct3 = cpu_funct3;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    if (host_gnt) begin
      // Host accesses are always full word.
      mem_we     = host_we;
      mem_funct3 = Funct3Word;
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
    end
  end

  // The CPU ignores this while stalled.
  assign cpu_rdata = mem_rdata;

  // ---------------------------------------------------------------------------
  // State: starvation counter and host read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= 4'd0;
      host_rdata  <= 32'd0;
      host_rvalid <= 1'b0;
    end else begin
      // Clearing after any grant guarantees the CPU wins the next MAX_WAIT
      // contended cycles, so forced stalls are never back to back.
      if (host_gnt || !host_req) begin
        wait_cnt <= 4'd0;
      end else if (!forced) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      host_rvalid <= host_rd_gnt;
      if (host_rd_gnt) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU load/store path and an external host port used for boot-time loading and runtime debug access.
- The CPU has priority. The host is granted idle cycles.
- A starvation counter forces a host grant after MAX_WAIT denied cycles; on that cycle the CPU is stalled.
- Sits between riscv_cpu / the external load interface and data_mem. It replaces the ad-hoc reset-time muxing at the top level.

Parameters:
- MAX_WAIT, 4: consecutive denied host cycles before a forced grant. Legal range 1..15; the counter is 4 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU performs a load or store this cycle
- cpu_we  in  1  CPU store
- cpu_funct3  in  3  CPU access size (data_mem store/load encoding)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data to CPU (combinational copy of mem_rdata)
- cpu_stall  out  1  CPU must hold its access and retry next cycle
- host_req  in  1  host access request, held until granted
- host_we  in  1  host write (1) / read (0)
- host_addr  in  32  host byte address
- host_wdata  in  32  host write data
- host_gnt  out  1  host access performed this cycle
- host_rdata  out  32  registered host read data
- host_rvalid  out  1  host_rdata valid, 1-cycle pulse
- mem_we  out  1  data_mem write enable
- mem_funct3  out  3  data_mem size select
- mem_addr  out  32  data_mem address
- mem_wdata  out  32  data_mem write data
- mem_rdata  in  32  data_mem combinational read data

Behaviour:
- State: wait_cnt (4 bits), host_rdata (32), host_rvalid (1). All clear to 0 on any clock edge with reset=1, including mid-access.

Grant logic (combinational), reset=1:
- host_gnt = host_req & host_we. Boot-load writes only.
- cpu_stall = 0.
- CPU accesses are never forwarded: mem_we is driven only by a host grant.
- Host reads wait until reset deasserts.

Grant logic (combinational), reset=0:
- host_gnt = host_req & (!cpu_req | wait_cnt == MAX_WAIT).
- cpu_stall = cpu_req & host_gnt.

Memory mux:
- When host_gnt=1: mem_we=host_we, mem_funct3=3'b010 (host accesses are always full word), mem_addr=host_addr, mem_wdata=host_wdata.
- Otherwise: mem_we = cpu_req & cpu_we & !reset, mem_funct3=cpu_funct3, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- cpu_rdata = mem_rdata at all times. The CPU ignores it while stalled.

wait_cnt update (reset=0), in priority order:
- host_gnt, or !host_req: cleared to 0.
- Otherwise: increments, saturating at MAX_WAIT.

Forced grant and fairness:
- The forced grant happens on the cycle wait_cnt == MAX_WAIT; this is latency MAX_WAIT+1 from the first denied cycle.
- After any grant wait_cnt=0, so the CPU wins at least the next MAX_WAIT contended cycles. No back-to-back forced stalls.

Host read return:
- A host read granted in cycle N captures mem_rdata into host_rdata at the end of N.
- host_rvalid=1 during N+1 only. host_rdata holds its value until the next host read.

Host protocol:
- Host holds host_req and its operands stable until host_gnt is seen high.
- The host may drop host_req on the grant cycle or issue a new request immediately.
- Back-to-back host grants are legal when the CPU is idle.

Simultaneous events:
- Host write and CPU store in the same cycle: exactly one reaches memory. The loser is the CPU only on a forced grant; otherwise the host is denied.
- reset asserted in the same cycle as a forced grant: the reset grant rule applies.

Test Plan:
- reset=1, host_req=1, host_we=1, host_addr=0x10, host_wdata=0xDEADBEEF for 1 cycle -> host_gnt=1, mem_we=1, mem_funct3=3'b010, cpu_stall=0. After release, a CPU lw (funct3=3'b010) from 0x10 returns cpu_rdata=0xDEADBEEF.
- reset=0, cpu_req=0, host read of 0x10 -> host_gnt=1 in cycle N; host_rvalid=1 with host_rdata=0xDEADBEEF in N+1; host_rvalid=0 in N+2.
- cpu_req held 1 continuously, host_req=1 from cycle 0, MAX_WAIT=4 -> host_gnt=0 and cpu_stall=0 in cycles 0-3; host_gnt=1 and cpu_stall=1 in cycle 4; then wait_cnt=0 and no stall in cycle 5.
- Continuous contention over 20 cycles -> forced grants at cycles 4, 9, 14, 19 only; cpu_stall asserted exactly those 4 cycles.
- reset=1, host read request -> host_gnt=0, no host_rvalid. After reset=0 with the CPU idle -> granted on the first cycle, rvalid on the next.
- reset asserted while wait_cnt=3 and host_rvalid=1 -> next cycle wait_cnt=0, host_rvalid=0, host_rdata=0. After release, a contended host read needs a full MAX_WAIT+1 cycles.
